// File: rtl/seq_gen_n.sv
// Sequence generator with up, down, gray and ping-pong modes.
// IDLE/RUN/HOLD control; q is decoded from the registered index and latched mode.
module seq_gen_n #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LAST  = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             show,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_GRAY = 2'b10,
    M_PING = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_idx;
  logic [1:0]       r_mreg;
  logic             r_dir;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_idx;
  logic             w_next_dir;
  logic             w_next_wrap;

  always_comb begin
    w_next_idx  = r_idx;
    w_next_dir  = r_dir;
    w_next_wrap = 1'b0;
    case (mode_t'(r_mreg))
      M_DOWN: begin
        if (r_idx == '0) begin
          w_next_idx  = LAST_V;
          w_next_wrap = 1'b1;
        end else begin
          w_next_idx = r_idx - ONE_V;
        end
      end
      M_PING: begin
        // Direction turns on the step that leaves an endpoint, so neither end repeats.
        if (r_dir) begin
          if (r_idx == LAST_V) begin
            w_next_idx = r_idx - ONE_V;
            w_next_dir = 1'b0;
          end else begin
            w_next_idx = r_idx + ONE_V;
          end
        end else begin
          if (r_idx == '0) begin
            w_next_idx = ONE_V;
            w_next_dir = 1'b1;
          end else begin
            w_next_idx = r_idx - ONE_V;
          end
        end
        w_next_wrap = (r_idx == ONE_V) && (w_next_idx == '0);
      end
      default: begin
        if (r_idx == LAST_V) begin
          w_next_idx  = '0;
          w_next_wrap = 1'b1;
        end else begin
          w_next_idx = r_idx + ONE_V;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dir   <= 1'b1;
      r_mreg  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!show) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_dir   <= 1'b1;
        r_mreg  <= '0;
      end else if (stop) begin
        if (r_state == RUN) r_state <= HOLD;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= RUN;
            r_mreg  <= mode;
            r_idx   <= (mode == M_DOWN) ? LAST_V : '0;
            r_dir   <= 1'b1;
          end
          HOLD: r_state <= RUN;
          RUN: begin
            r_idx  <= w_next_idx;
            r_dir  <= w_next_dir;
            r_wrap <= w_next_wrap;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign q       = (r_mreg == M_GRAY) ? (r_idx ^ (r_idx >> 1)) : r_idx;
  assign running = (r_state == RUN);
  assign wrap    = r_wrap;

endmodule
